// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and ALU operand/result bus between the sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the instruction source plus ALU.
interface alu_op_sequencer_if #(
    parameter int unsigned REG_AW = 2
);
    localparam int unsigned INSTR_W = 3 + 3 * REG_AW;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [2:0]         alu_op;
    logic [7:0]         alu_a;
    logic [7:0]         alu_b;
    logic [7:0]         alu_res;
    logic               alu_ac;
    logic               alu_c;
    logic               alu_z;
    logic               alu_s;

    modport master (
        input  in_valid, in_instr, alu_res, alu_ac, alu_c, alu_z, alu_s,
        output in_ready, alu_op, alu_a, alu_b
    );

    modport slave (
        output in_valid, in_instr, alu_res, alu_ac, alu_c, alu_z, alu_s,
        input  in_ready, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator for an 8-bit combinational ALU: fetches operands from a small register file,
// holds them for a settle time, then writes back the result and latches the flags.
module alu_op_sequencer #(
    parameter int unsigned REG_AW        = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_sequencer_if.master   bus,
    input  logic                 ld_en,
    input  logic [REG_AW-1:0]    ld_addr,
    input  logic [7:0]           ld_data,
    input  logic [REG_AW-1:0]    rd_addr,
    output logic [7:0]           rd_data,
    output logic                 flag_ac,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_s,
    output logic                 done,
    output logic [7:0]           res_q
);
    localparam int unsigned NREG    = 1 << REG_AW;
    localparam int unsigned DW      = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned INSTR_W = 3 + 3 * REG_AW;
    localparam logic [2:0]  OP_ADD  = 3'b000;
    localparam logic [2:0]  OP_SUB  = 3'b001;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [2:0]          op_q, op_d;
    logic [DW-1:0]       a_q, a_d;
    logic [DW-1:0]       b_q, b_d;
    logic [DW-1:0]       res_r_q, res_d;
    logic [3:0]          flags_q, flags_d;   // {ac, c, z, s}
    logic                done_q, done_d;
    logic [DW-1:0]       regs_q [NREG];
    logic [DW-1:0]       regs_d [NREG];

    logic [INSTR_W-1:0]  instr;
    logic [2:0]          instr_op;
    logic [REG_AW-1:0]   instr_rd, instr_rs1, instr_rs2;

    assign instr     = bus.in_instr;
    assign instr_op  = instr[INSTR_W-1 -: 3];
    assign instr_rd  = instr[3*REG_AW-1 -: REG_AW];
    assign instr_rs1 = instr[2*REG_AW-1 -: REG_AW];
    assign instr_rs2 = instr[REG_AW-1:0];

    // Next-state and datapath; the writeback assignment follows the load so it wins on a clash.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_r_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        regs_d  = regs_q;

        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    a_d     = regs_q[instr_rs1];
                    b_d     = regs_q[instr_rs2];
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    regs_d[rd_q] = bus.alu_res;
                    res_d        = bus.alu_res;
                    flags_d[1]   = bus.alu_z;
                    // Carry, aux-carry and sign only mean something for arithmetic ops.
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        flags_d[3] = bus.alu_ac;
                        flags_d[2] = bus.alu_c;
                        flags_d[0] = bus.alu_s;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_r_q <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_r_q <= res_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.alu_op   = op_q;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign rd_data      = regs_q[rd_addr];
    assign res_q        = res_r_q;
    assign done         = done_q;
    assign flag_ac      = flags_q[3];
    assign flag_c       = flags_q[2];
    assign flag_z       = flags_q[1];
    assign flag_s       = flags_q[0];
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts instruction words over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU opcode and operand lines, waits a fixed settle time, then captures the ALU result and flags.
- Writes the result back to the destination register, latches the flags, and pulses done.
- Sits between the instruction source/memory and the combinational ALU.

Parameters:
- REG_AW, 2, register-file address width; the file holds 2**REG_AW 8-bit registers.
- SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction (high only in IDLE).
- in_instr  in  3+3*REG_AW  {op[2:0], rd, rs1, rs2}, op in the MSBs.
- ld_en  in  1  direct register load strobe.
- ld_addr  in  REG_AW  load target register.
- ld_data  in  8  load value.
- rd_addr  in  REG_AW  debug read address.
- rd_data  out  8  combinational read of regfile[rd_addr].
- alu_op  out  3  opcode to ALU, registered.
- alu_a  out  8  operand A to ALU, registered.
- alu_b  out  8  operand B to ALU, registered.
- alu_res  in  8  ALU result.
- alu_ac, alu_c, alu_z, alu_s  in  1 each  ALU auxiliary-carry, carry, zero and sign flags.
- flag_ac, flag_c, flag_z, flag_s  out  1 each  latched flags.
- done  out  1  one-cycle pulse on writeback.
- res_q  out  8  last written-back result.

Behaviour:
- Opcode encoding: ADD 000, SUB 001, COMP 010 (two's-complement negate of A; B ignored by ALU), AND 011, OR 100, NAND 101, NOR 110, XOR 111.
- Reset (async, immediate): state=IDLE; all registers, alu_op/alu_a/alu_b, flags, res_q, done = 0.
- A reset mid-operation discards the in-flight instruction; no writeback and no done.
- FSM states: IDLE, WAIT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch rd; alu_op<=op; alu_a<=reg[rs1]; alu_b<=reg[rs2], using pre-edge register values; cnt<=SETTLE_CYCLES-1; go to WAIT.
- WAIT:
  - in_ready=0; alu_* held stable; in_valid is ignored.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 on an edge:
    - reg[rd]<=alu_res; res_q<=alu_res.
    - flag_z<=alu_z for all ops.
    - flag_c, flag_ac, flag_s <= ALU values only for ADD/SUB; they hold for all other ops.
    - done<=1 for exactly one cycle; go to IDLE.
- Latency: instruction accepted at edge k → writeback and done asserted at edge k+SETTLE_CYCLES. in_ready is high again in the same cycle as done.
- Throughput: one instruction per SETTLE_CYCLES+1 cycles.
- Back-to-back dependency: an instruction accepted in the done cycle reads the freshly written value, so no hazard.
- Load port:
  - ld_en writes reg[ld_addr]<=ld_data on any edge, in any state.
  - Same edge and same register as a writeback: writeback wins.
  - Same edge as an accept that reads that register: the operand takes the old value.
- The source registers of an in-flight op may be reloaded; alu_a/alu_b are unaffected.
- done is 0 in all cycles except the writeback pulse.
- rd_data is purely combinational and reflects writes the cycle after the edge.

Test Plan:
- Load R0=0x0F, R1=0x01; ADD rd=R2, rs1=R0, rs2=R1 → done at accept+1 edge; R2=0x10; res_q=0x10; ac=1, c=0, z=0, s=0.
- SUB rd=R3, rs1=R1, rs2=R0 (0x01-0x0F) → R3=0xF2; ac=1, c=1, s=1, z=0.
- After the SUB, XOR rd=R2, rs1=R0, rs2=R0 → R2=0x00; z=1; c/ac/s hold at 1/1/1.
- in_valid held high with SETTLE_CYCLES=3 → in_ready low for 3 cycles after each accept; done every 4 cycles; no instruction lost or duplicated.
- Assert rst during WAIT of an ADD to R2 → outputs 0 immediately; R2 stays 0; no done; in_ready=1 after release.
- ld_en to R2 with 0xAA on the same edge as an ADD writeback to R2 of 0x10 → R2=0x10; a load to R0 on an accept edge → alu_a holds the old R0.
